// File: rtl/reflex_tick_sched.sv
// reflex_tick_sched
//   Tick scheduler for the reflex trainer. A programmable prescaler on clk_i
//   produces one-cycle tick enables (no derived clocks). A round FSM runs on
//   those ticks: armed delay, stimulus (expire), then reaction measurement
//   until hit, false start or saturation.
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   run_i                   1 = prescaler and round advance, 0 = pause
//   cfg_valid_i/cfg_div_i   new divide ratio offer; cfg_ready_o = shadow free
//   arm_valid_i/arm_delay_i start a round; arm_ready_o high in IDLE/DONE
//   hit_i                   synchronised, debounced player response
//   tick_o                  one-cycle prescaler pulse
//   expire_o                one-cycle stimulus pulse
//   result_valid_o          one-cycle pulse on entry to DONE
//   elapsed_o               reaction time in ticks (held in DONE)
//   early_o, timeout_o      false start / saturation flags (held in DONE)
module reflex_tick_sched #(
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 100000,
  parameter int TIME_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              cfg_valid_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  output logic              cfg_ready_o,
  input  logic              arm_valid_i,
  input  logic [TIME_W-1:0] arm_delay_i,
  output logic              arm_ready_o,
  input  logic              hit_i,
  output logic              tick_o,
  output logic              expire_o,
  output logic              result_valid_o,
  output logic [TIME_W-1:0] elapsed_o,
  output logic              early_o,
  output logic              timeout_o
);

  localparam logic [CNT_W-1:0]  DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

  // ---------------- prescaler and config shadow ----------------
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div_eff;
  logic             wrap;

  assign div_eff = (div_act_q == '0) ? CNT_W'(1) : div_act_q;
  // ">=" rather than "==": a ratio swapped in while paused may leave pcnt
  // above the new terminal count; the period then ends at the next edge.
  assign wrap = run_i && (pcnt_q >= div_eff - CNT_W'(1));

  always_comb begin
    pcnt_d    = pcnt_q;
    div_act_d = div_act_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    tick_d    = wrap;
    if (run_i) pcnt_d = wrap ? '0 : pcnt_q + CNT_W'(1);
    // Apply a pending ratio only on a period boundary (or while paused),
    // so div_act never changes in the middle of a running period.
    if (pend_q) begin
      if (wrap || !run_i) begin
        div_act_d = shadow_q;
        pend_d    = 1'b0;
      end
    end else if (cfg_valid_i) begin
      shadow_d = cfg_div_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q    <= '0;
      div_act_q <= DEF_DIV;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
    end
  end

  assign cfg_ready_o = !pend_q;
  assign tick_o      = tick_q;

  // ---------------- round FSM ----------------
  state_t            state_q, state_d;
  logic [TIME_W-1:0] dcnt_q, dcnt_d;
  logic [TIME_W-1:0] elapsed_q, elapsed_d;
  logic              early_q, early_d;
  logic              timeout_q, timeout_d;
  logic              expire_q, expire_d;
  logic              rv_q, rv_d;

  // The FSM consumes the registered tick, so expire lands one cycle after
  // the (D+1)th tick following arm.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    elapsed_d = elapsed_q;
    early_d   = early_q;
    timeout_d = timeout_q;
    expire_d  = 1'b0;
    rv_d      = 1'b0;
    if (run_i) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm_valid_i) begin
            state_d   = ARMED;
            dcnt_d    = arm_delay_i;
            elapsed_d = '0;
            early_d   = 1'b0;
            timeout_d = 1'b0;
          end
        end
        ARMED: begin
          if (hit_i) begin            // false start beats a same-cycle tick
            state_d   = DONE;
            early_d   = 1'b1;
            elapsed_d = '0;
            rv_d      = 1'b1;
          end else if (tick_q) begin
            if (dcnt_q == '0) begin
              state_d  = MEASURE;
              expire_d = 1'b1;
            end else begin
              dcnt_d = dcnt_q - TIME_W'(1);
            end
          end
        end
        MEASURE: begin
          if (hit_i) begin            // same-cycle tick is not counted
            state_d = DONE;
            rv_d    = 1'b1;
          end else if (tick_q) begin
            if (elapsed_q == TIME_MAX) begin
              state_d   = DONE;
              timeout_d = 1'b1;
              rv_d      = 1'b1;
            end else begin
              elapsed_d = elapsed_q + TIME_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      elapsed_q <= '0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      expire_q  <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      elapsed_q <= elapsed_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      expire_q  <= expire_d;
      rv_q      <= rv_d;
    end
  end

  assign arm_ready_o    = (state_q == IDLE) || (state_q == DONE);
  assign expire_o       = expire_q;
  assign result_valid_o = rv_q;
  assign elapsed_o      = elapsed_q;
  assign early_o        = early_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_reflex_tick_sched.sv
// Bench for reflex_tick_sched: directed scenarios followed by random traffic,
// all compared every cycle against a tick-counting reference model.
module tb_reflex_tick_sched;
  localparam int CNT_W = 8, DEFAULT_DIV = 4, TIME_W = 4;
  localparam int TMAX = (1 << TIME_W) - 1;

  logic clk = 1'b0;
  logic rst, run, cfg_valid, arm_valid, hit;
  logic [CNT_W-1:0]  cfg_div;
  logic [TIME_W-1:0] arm_delay;
  logic cfg_ready, arm_ready, tick, expire, result_valid, early, timeout;
  logic [TIME_W-1:0] elapsed;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  reflex_tick_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .TIME_W(TIME_W)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run),
    .cfg_valid_i(cfg_valid), .cfg_div_i(cfg_div), .cfg_ready_o(cfg_ready),
    .arm_valid_i(arm_valid), .arm_delay_i(arm_delay), .arm_ready_o(arm_ready),
    .hit_i(hit), .tick_o(tick), .expire_o(expire), .result_valid_o(result_valid),
    .elapsed_o(elapsed), .early_o(early), .timeout_o(timeout));

  // Reference model: period position, tick count since arm, phase of round.
  // phase: 0 idle, 1 waiting for stimulus, 2 measuring, 3 result held
  int m_pos, m_div, m_shadow, m_tick, m_phase, m_ticks_seen, m_delay;
  int m_elapsed, m_early, m_timeout, m_expire, m_rv;
  bit m_pend;

  task automatic model_step();
    int period, nxt_tick, nxt_pos;
    if (rst) begin
      m_pos = 0; m_div = DEFAULT_DIV; m_shadow = 0; m_pend = 0; m_tick = 0;
      m_phase = 0; m_ticks_seen = 0; m_delay = 0;
      m_elapsed = 0; m_early = 0; m_timeout = 0; m_expire = 0; m_rv = 0;
      return;
    end
    period   = (m_div == 0) ? 1 : m_div;
    nxt_tick = (run && m_pos + 1 >= period) ? 1 : 0;
    nxt_pos  = !run ? m_pos : (nxt_tick ? 0 : m_pos + 1);
    if (m_pend) begin
      if (nxt_tick || !run) begin m_div = m_shadow; m_pend = 0; end
    end else if (cfg_valid) begin
      m_shadow = cfg_div; m_pend = 1;
    end
    m_expire = 0; m_rv = 0;
    if (run) begin
      case (m_phase)
        0, 3: if (arm_valid) begin
          m_phase = 1; m_ticks_seen = 0; m_delay = arm_delay;
          m_elapsed = 0; m_early = 0; m_timeout = 0;
        end
        1: if (hit) begin
          m_phase = 3; m_early = 1; m_elapsed = 0; m_rv = 1;
        end else if (m_tick == 1) begin
          m_ticks_seen++;
          if (m_ticks_seen == m_delay + 1) begin m_phase = 2; m_expire = 1; end
        end
        2: if (hit) begin
          m_phase = 3; m_rv = 1;
        end else if (m_tick == 1) begin
          if (m_elapsed == TMAX) begin m_phase = 3; m_timeout = 1; m_rv = 1; end
          else m_elapsed++;
        end
        default: ;
      endcase
    end
    m_pos = nxt_pos; m_tick = nxt_tick;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_all();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("expire", 32'(expire), 32'(m_expire));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("elapsed", 32'(elapsed), 32'(m_elapsed));
    chk("early", 32'(early), 32'(m_early));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("arm_ready", 32'(arm_ready), 32'(m_phase == 0 || m_phase == 3));
  endtask

  // One clock: inputs already set, advance model, sample #1 after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    rst = 0; cfg_valid = 0; arm_valid = 0; hit = 0;
  endtask

  task automatic do_reset();
    rst = 1; run = 0; cfg_valid = 0; arm_valid = 0; hit = 0; cfg_div = '0; arm_delay = '0;
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic set_div(input int d);
    int n;
    cfg_valid = 1; cfg_div = CNT_W'(d);
    cycle();
    cfg_valid = 0;
    n = 0;
    while (!cfg_ready && n < 300) begin cycle(); n++; end
    if (n >= 300) chk("cfg_apply_wait", 0, 1);
  endtask

  task automatic arm(input int d);
    arm_valid = 1; arm_delay = TIME_W'(d);
    cycle();
    arm_valid = 0;
  endtask

  initial begin
    int n, first, last, gap, rv_cnt, exp_seen, el_hold;

    // 1. reset state, default divide of 4
    do_reset();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_elapsed", 32'(elapsed), 0);
    chk("rst_flags", 32'({expire, result_valid, early, timeout}), 0);
    chk("rst_readies", 32'({cfg_ready, arm_ready}), 32'h3);
    run = 1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      chk("t1_tick_every4", 32'(tick), 32'(i % 4 == 0));
    end

    // 2. new ratio offered mid-period: finishes the 4-period, then 2
    cycle();
    cfg_valid = 1; cfg_div = 8'd2;
    cycle();
    cfg_valid = 0;
    chk("t2_cfg_ready_low", 32'(cfg_ready), 0);
    n = 0;
    while (!cfg_ready && n < 20) begin cycle(); n++; end
    chk("t2_cfg_ready_back", 32'(cfg_ready), 1);
    first = -1; last = -1; gap = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (tick) begin
        if (last >= 0 && gap == 0) gap = i - last;
        last = i;
      end
    end
    chk("t2_gap2", 32'(gap), 2);

    // 3. div 1, delay 3, hit once elapsed reaches 5
    set_div(1);
    arm(3);
    exp_seen = 0; n = 0;
    while (m_phase != 2 && n < 30) begin
      cycle(); n++;
      if (expire) exp_seen++;
    end
    chk("t3_expire_seen", 32'(exp_seen), 1);
    n = 0;
    while (m_elapsed != 5 && n < 30) begin cycle(); n++; end
    hit = 1; cycle(); hit = 0;
    chk("t3_rv", 32'(result_valid), 1);
    chk("t3_elapsed5", 32'(elapsed), 5);
    chk("t3_early0", 32'(early), 0);

    // 4. false start: delay 10, hit after 2 ticks (div 2)
    set_div(2);
    arm(10);
    exp_seen = 0; n = 0;
    while (m_ticks_seen < 2 && n < 40) begin
      cycle(); n++;
      if (expire) exp_seen++;
    end
    hit = 1; cycle(); hit = 0;
    chk("t4_rv", 32'(result_valid), 1);
    chk("t4_early", 32'(early), 1);
    chk("t4_elapsed0", 32'(elapsed), 0);
    for (int i = 0; i < 30; i++) begin cycle(); if (expire) exp_seen++; end
    chk("t4_no_expire", 32'(exp_seen), 0);

    // 5. saturation at TIME_W max
    set_div(1);
    arm(0);
    rv_cnt = 0;
    for (int i = 0; i < 40; i++) begin cycle(); if (result_valid) rv_cnt++; end
    chk("t5_rv_once", 32'(rv_cnt), 1);
    chk("t5_elapsed_max", 32'(elapsed), 32'(TMAX));
    chk("t5_timeout", 32'(timeout), 1);

    // 6. pause during MEASURE, then reset mid-ARMED
    arm(1);
    n = 0;
    while (m_elapsed < 3 && n < 30) begin cycle(); n++; end
    el_hold = elapsed;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("t6_paused_elapsed", 32'(elapsed), 32'(el_hold));
    end
    run = 1;
    hit = 1; cycle(); hit = 0;
    arm(9);
    cycle(); cycle();
    rst = 1; cycle(); rst = 0;
    chk("t6_rst_arm_ready", 32'(arm_ready), 1);
    chk("t6_rst_outs", 32'({tick, expire, result_valid, early, timeout}), 0);
    chk("t6_rst_elapsed", 32'(elapsed), 0);

    // 7. random traffic
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      run       = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 4));
      arm_valid = ($urandom_range(0, 7) == 0);
      arm_delay = TIME_W'($urandom_range(0, 5));
      hit       = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
